wb_capture_sequencer: RTL and testbench
=======================================

Name: wb_capture_sequencer

Overview:
- Wishbone master that programs the camera capture path without CPU involvement.
- Programs the format regularizer and write DMA, then starts capture.
- Supervises capture: polls DMA status; on request, stops the DMA and drains it.
- Sits beside the peripheral bus master on the wb_peri bus, clocked by wb_clk_i; drives the same register map as software.

Parameters:
- WB_ADR_WIDTH, 30, word address width.
- WB_DAT_WIDTH, 32, data width (sel width = WB_DAT_WIDTH/8).
- FMTREG_BASE, 30'h1000_4000, word base of format regularizer (byte 0x4001_0000).
- WDMA_BASE, 30'h1000_8400, word base of write DMA (byte 0x4002_1000).
- FMT_TIMEOUT, 1024, value written to regularizer timeout register.
- POLL_INTERVAL, 256, idle cycles between status reads (must be ≥1).
- ACK_TIMEOUT, 4096, cycles allowed per bus access before error.

Ports:
- wb_rst_i, in, 1, asynchronous reset, active-low.
- wb_clk_i, in, 1, clock.
- start, in, 1, one-cycle pulse: begin sequence (ignored unless IDLE).
- stop, in, 1, one-cycle pulse: request stop (ignored in IDLE; latched otherwise).
- cfg_oneshot, in, 1, capture a single frame.
- cfg_width, in, 16, frame width in pixels.
- cfg_height, in, 16, frame height in lines.
- cfg_addr, in, 32, DMA base address.
- cfg_awlen, in, 8, DMA burst length − 1.
- busy, out, 1, high in any state other than IDLE.
- done, out, 1, one-cycle pulse when capture has ended cleanly.
- error, out, 1, sticky; set on ack timeout; cleared by next accepted start.
- m_wb_adr_o, out, WB_ADR_WIDTH, word address.
- m_wb_dat_o, out, WB_DAT_WIDTH, write data.
- m_wb_dat_i, in, WB_DAT_WIDTH, read data.
- m_wb_we_o, out, 1, write enable.
- m_wb_sel_o, out, WB_SEL_WIDTH, byte select (all ones).
- m_wb_stb_o, out, 1, strobe.
- m_wb_ack_i, in, 1, acknowledge.

Behaviour:
- Reset: all outputs 0, state IDLE, step=0, stop latch clear.
- cfg_* are sampled into internal registers on the accepted start; later changes are ignored.
- Derived values: stride = 4*width, zero-extended to 32 bits. size = width*height, full 32-bit product.
- Bus cycle:
  - stb, adr, dat and we are asserted from a register and held constant until ack.
  - stb drops the cycle after ack is sampled; at least one idle cycle follows each access.
  - Read data is captured on the ack cycle.
- Access counter resets at each stb rise. Reaching ACK_TIMEOUT without ack: drop stb, set error, go to IDLE, no done pulse.
- States:
  - IDLE: on start → CFG (step=0).
  - CFG: fixed write list, one access per step:
    - FMT+0x10 width; FMT+0x11 height; FMT+0x12 0; FMT+0x13 FMT_TIMEOUT; FMT+0x04 1.
    - WDMA+0x08 addr; +0x09 stride; +0x0A width; +0x0B height; +0x0C size; +0x0F awlen.
    - WDMA+0x04 = oneshot ? 7 : 3.
    - After the last write → RUN.
  - RUN: wait POLL_INTERVAL cycles. Then, if stop is latched → STOP_WR; else if oneshot → POLL_RD; else remain in RUN.
  - POLL_RD: read WDMA+0x05. Data==0 → DONE; else → RUN.
  - STOP_WR: write WDMA+0x04 = 0 → DRAIN.
  - DRAIN: wait POLL_INTERVAL, read WDMA+0x05; repeat until data==0 → DONE.
  - DONE: done=1 for one cycle, clear stop latch → IDLE.
- A stop arriving during CFG is latched and acted upon at the first RUN decision; the config list always completes.
- start while busy is ignored.
- stop and start in the same cycle from IDLE: start wins, and stop is latched.
- Reset mid-transaction: stb drops asynchronously; no further accesses.

Optional Feature:
- Macro WB_CAPTURE_SEQ_ID_CHECK_EN.
- Defined: before CFG, read FMT+0x00 and WDMA+0x00.
  - If either result is 0 or all-ones, set error and return to IDLE without any writes.
  - Otherwise proceed to CFG.
- Undefined: the ID reads are omitted and CFG begins the cycle after start.

Test Plan:
- Continuous capture: width=2048, height=16, addr=0x3000_0000, awlen=31, oneshot=0, then start. Required:
  - Exactly 12 writes in the listed order.
  - Stride 8192, size 32768, ctl 3.
  - busy=1 throughout; no done pulse.
- Stop path: from RUN, pulse stop; model reports status 1,1,0. Required:
  - Write of ctl=0.
  - Three status reads.
  - done pulses once; busy falls on the same cycle.
- Oneshot with mismatched geometry: width=320, height=64, oneshot=1; model status goes 0 after 3 polls. Required:
  - ctl=7, size=20480.
  - done pulses; no stop write.
- Ack timeout: slave never acks the 5th write. Required:
  - stb drops after ACK_TIMEOUT cycles.
  - error=1; no done; next start clears error.
- Async reset asserted mid-write: stb=0 immediately; after release, state IDLE and no bus activity until start.
- ID check (macro defined): slave returns 0 for WDMA+0x00. Required: error=1, zero writes issued.

Source files
------------

// File: rtl/wb_capture_sequencer_if.sv
// Wishbone classic bundle between the capture sequencer and wb_peri.
// Master drives adr/dat_o/we/sel/stb; slave returns dat_i/ack.
interface wb_capture_sequencer_if #(
  parameter int AW = 30,
  parameter int DW = 32
);
  logic [AW-1:0]   m_wb_adr_o;
  logic [DW-1:0]   m_wb_dat_o;
  logic [DW-1:0]   m_wb_dat_i;
  logic            m_wb_we_o;
  logic [DW/8-1:0] m_wb_sel_o;
  logic            m_wb_stb_o;
  logic            m_wb_ack_i;

  modport master (
    output m_wb_adr_o,
    output m_wb_dat_o,
    output m_wb_we_o,
    output m_wb_sel_o,
    output m_wb_stb_o,
    input  m_wb_dat_i,
    input  m_wb_ack_i
  );

  modport slave (
    input  m_wb_adr_o,
    input  m_wb_dat_o,
    input  m_wb_we_o,
    input  m_wb_sel_o,
    input  m_wb_stb_o,
    output m_wb_dat_i,
    output m_wb_ack_i
  );
endinterface

// File: rtl/wb_capture_sequencer.sv
// Wishbone master: programs fmt regularizer + write DMA, runs/stops capture.
// Ports: wb_clk_i, wb_rst_i (async, active-low), start/stop pulses,
//   cfg_* (sampled on start), busy/done/error, m_wb (Wishbone master).
// Option WB_CAPTURE_SEQ_ID_CHECK_EN: read both block IDs before configuring.
module wb_capture_sequencer #(
  parameter int WB_ADR_WIDTH = 30,
  parameter int WB_DAT_WIDTH = 32,
  parameter logic [WB_ADR_WIDTH-1:0] FMTREG_BASE = 30'h1000_4000,
  parameter logic [WB_ADR_WIDTH-1:0] WDMA_BASE = 30'h1000_8400,
  parameter int FMT_TIMEOUT = 1024,
  parameter int POLL_INTERVAL = 256,
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic        wb_rst_i,
  input  logic        wb_clk_i,
  input  logic        start,
  input  logic        stop,
  input  logic        cfg_oneshot,
  input  logic [15:0] cfg_width,
  input  logic [15:0] cfg_height,
  input  logic [31:0] cfg_addr,
  input  logic [7:0]  cfg_awlen,
  output logic        busy,
  output logic        done,
  output logic        error,
  wb_capture_sequencer_if.master m_wb
);
  localparam int A = WB_ADR_WIDTH;
  localparam int D = WB_DAT_WIDTH;
  localparam logic [31:0] TO_LAST = 32'(ACK_TIMEOUT - 1);
  localparam logic [31:0] PI_LAST = 32'(POLL_INTERVAL - 1);
  localparam logic [3:0] LAST_STEP = 4'd11;

  typedef enum logic [3:0] {
    S_IDLE, S_ID_FMT, S_ID_WDMA, S_CFG, S_RUN,
    S_POLL, S_STOP, S_DRAIN, S_DRAIN_RD
  } state_t;

  state_t state;
  logic [3:0]  step;
  logic [31:0] cnt;
  logic        stop_q;
  logic [15:0] w_q, h_q;
  logic [31:0] addr_q;
  logic [7:0]  awlen_q;
  logic        oneshot_q;
  logic        stb_q, we_q;
  logic [A-1:0] adr_q;
  logic [D-1:0] dat_q;
  logic [D/8-1:0] sel_q;

  logic [31:0]  stride, size;
  logic [A-1:0] acc_adr;
  logic [D-1:0] acc_dat;
  logic         acc_we, is_acc, rd_zero;

  function automatic logic [A-1:0] fa(input int off);
    return FMTREG_BASE + A'(off);
  endfunction

  function automatic logic [A-1:0] wa(input int off);
    return WDMA_BASE + A'(off);
  endfunction

  assign stride = {14'd0, w_q, 2'b00};
  assign size = 32'(w_q) * 32'(h_q);
  assign rd_zero = (m_wb.m_wb_dat_i == '0);
  assign is_acc = state inside {S_ID_FMT, S_ID_WDMA, S_CFG,
                                S_POLL, S_STOP, S_DRAIN_RD};

`ifdef WB_CAPTURE_SEQ_ID_CHECK_EN
  logic id_bad;
  assign id_bad = rd_zero || (&m_wb.m_wb_dat_i);
`endif

  always_comb begin
    acc_adr = wa('h05);
    acc_dat = '0;
    acc_we = 1'b0;
    unique case (state)
      S_CFG: begin
        acc_we = 1'b1;
        case (step)
          4'd0: begin acc_adr = fa('h10); acc_dat = D'(w_q); end
          4'd1: begin acc_adr = fa('h11); acc_dat = D'(h_q); end
          4'd2: begin acc_adr = fa('h12); acc_dat = '0; end
          4'd3: begin
            acc_adr = fa('h13);
            acc_dat = D'(FMT_TIMEOUT);
          end
          4'd4: begin acc_adr = fa('h04); acc_dat = D'(1); end
          4'd5: begin acc_adr = wa('h08); acc_dat = D'(addr_q); end
          4'd6: begin acc_adr = wa('h09); acc_dat = D'(stride); end
          4'd7: begin acc_adr = wa('h0A); acc_dat = D'(w_q); end
          4'd8: begin acc_adr = wa('h0B); acc_dat = D'(h_q); end
          4'd9: begin acc_adr = wa('h0C); acc_dat = D'(size); end
          4'd10: begin acc_adr = wa('h0F); acc_dat = D'(awlen_q); end
          default: begin
            acc_adr = wa('h04);
            acc_dat = oneshot_q ? D'(7) : D'(3);
          end
        endcase
      end
      S_STOP: begin acc_adr = wa('h04); acc_we = 1'b1; end
      S_ID_FMT: acc_adr = fa('h00);
      S_ID_WDMA: acc_adr = wa('h00);
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state <= S_IDLE;
      step <= '0;
      cnt <= '0;
      stop_q <= 1'b0;
      w_q <= '0;
      h_q <= '0;
      addr_q <= '0;
      awlen_q <= '0;
      oneshot_q <= 1'b0;
      stb_q <= 1'b0;
      we_q <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop && state != S_IDLE) stop_q <= 1'b1;
      if (is_acc) begin
        if (!stb_q) begin
          stb_q <= 1'b1;
          adr_q <= acc_adr;
          dat_q <= acc_dat;
          we_q <= acc_we;
          sel_q <= '1;
          cnt <= '0;
        end else if (m_wb.m_wb_ack_i) begin
          // stb falls here, guaranteeing an idle cycle before the next access
          stb_q <= 1'b0;
          cnt <= '0;
          unique case (state)
`ifdef WB_CAPTURE_SEQ_ID_CHECK_EN
            S_ID_FMT, S_ID_WDMA: begin
              if (id_bad) begin
                error <= 1'b1;
                busy <= 1'b0;
                stop_q <= 1'b0;
                state <= S_IDLE;
              end else if (state == S_ID_FMT) begin
                state <= S_ID_WDMA;
              end else begin
                state <= S_CFG;
              end
            end
`endif
            S_CFG: begin
              if (step == LAST_STEP) state <= S_RUN;
              else step <= step + 4'd1;
            end
            S_STOP: state <= S_DRAIN;
            S_POLL, S_DRAIN_RD: begin
              if (rd_zero) begin
                done <= 1'b1;
                busy <= 1'b0;
                stop_q <= 1'b0;
                state <= S_IDLE;
              end else begin
                state <= (state == S_POLL) ? S_RUN : S_DRAIN;
              end
            end
            default: ;
          endcase
        end else if (cnt == TO_LAST) begin
          stb_q <= 1'b0;
          error <= 1'b1;
          busy <= 1'b0;
          stop_q <= 1'b0;
          state <= S_IDLE;
        end else begin
          cnt <= cnt + 32'd1;
        end
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              w_q <= cfg_width;
              h_q <= cfg_height;
              addr_q <= cfg_addr;
              awlen_q <= cfg_awlen;
              oneshot_q <= cfg_oneshot;
              stop_q <= stop;
              error <= 1'b0;
              busy <= 1'b1;
              step <= '0;
`ifdef WB_CAPTURE_SEQ_ID_CHECK_EN
              state <= S_ID_FMT;
`else
              state <= S_CFG;
`endif
            end
          end
          S_RUN: begin
            if (cnt == PI_LAST) begin
              cnt <= '0;
              if (stop_q) state <= S_STOP;
              else if (oneshot_q) state <= S_POLL;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          S_DRAIN: begin
            if (cnt == PI_LAST) state <= S_DRAIN_RD;
            else cnt <= cnt + 32'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign m_wb.m_wb_adr_o = adr_q;
  assign m_wb.m_wb_dat_o = dat_q;
  assign m_wb.m_wb_we_o = we_q;
  assign m_wb.m_wb_sel_o = sel_q;
  assign m_wb.m_wb_stb_o = stb_q;
endmodule

// File: tb/tb_wb_capture_sequencer.sv
// Directed bench for wb_capture_sequencer with a logging Wishbone slave.
// Ports driven: clk, async reset, start/stop, cfg_*; bus via interface.
module tb_wb_capture_sequencer;
  localparam int PI = 4;
  localparam int TO = 16;
  localparam logic [29:0] FMT = 30'h1000_4000;
  localparam logic [29:0] WDMA = 30'h1000_8400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic oneshot = 1'b0;
  logic [15:0] width = '0;
  logic [15:0] height = '0;
  logic [31:0] addr = '0;
  logic [7:0] awlen = '0;
  logic busy, done, error;

  wb_capture_sequencer_if #(.AW(30), .DW(32)) bus();

  wb_capture_sequencer #(
    .POLL_INTERVAL(PI),
    .ACK_TIMEOUT(TO)
  ) dut (
    .wb_rst_i(rst_n),
    .wb_clk_i(clk),
    .start(start),
    .stop(stop),
    .cfg_oneshot(oneshot),
    .cfg_width(width),
    .cfg_height(height),
    .cfg_addr(addr),
    .cfg_awlen(awlen),
    .busy(busy),
    .done(done),
    .error(error),
    .m_wb(bus)
  );

  always #5 clk = ~clk;

  logic [29:0] wr_adr [0:63];
  logic [31:0] wr_dat [0:63];
  logic [31:0] st_seq [0:7];
  int st_len = 0, st_base = 0, noack_at = -1;
  logic [31:0] fmt_id = 32'h0000_1234;
  logic [31:0] wdma_id = 32'h0000_5678;
  int wr_n = 0, rd_n = 0, id_n = 0;
  int stb_run = 0, last_run = 0, stb_total = 0;
  int done_cnt = 0, busy_bad = 0;
  logic prev_busy = 1'b0;
  int n_tests = 0, n_fail = 0;

  always @(posedge clk) begin
    if (bus.m_wb_stb_o) begin
      stb_run++;
      stb_total++;
    end else begin
      if (stb_run != 0) last_run = stb_run;
      stb_run = 0;
    end
    bus.m_wb_ack_i <= 1'b0;
    if (rst_n && bus.m_wb_stb_o && !bus.m_wb_ack_i) begin
      if (bus.m_wb_we_o) begin
        if (wr_n != noack_at) begin
          if (wr_n < 64) begin
            wr_adr[wr_n] = bus.m_wb_adr_o;
            wr_dat[wr_n] = bus.m_wb_dat_o;
          end
          wr_n++;
          bus.m_wb_ack_i <= 1'b1;
        end
      end else begin
        bus.m_wb_ack_i <= 1'b1;
        if (bus.m_wb_adr_o == WDMA + 30'h5) begin
          if (rd_n - st_base < st_len && rd_n - st_base >= 0)
            bus.m_wb_dat_i <= st_seq[rd_n - st_base];
          else
            bus.m_wb_dat_i <= 32'h0;
          rd_n++;
        end else begin
          id_n++;
          bus.m_wb_dat_i <= (bus.m_wb_adr_o == FMT) ? fmt_id : wdma_id;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (busy || !prev_busy) busy_bad++;
    end
    prev_busy = busy;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [15:0] w, input logic [15:0] h,
                             input logic [31:0] a, input logic [7:0] l,
                             input logic os, input logic st);
    width = w; height = h; addr = a; awlen = l; oneshot = os;
    stop = st; start = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    width = 16'hffff; height = 16'hffff; addr = '1; awlen = '1;
    oneshot = ~os;
  endtask

  task automatic wait_done(input int d0, input int budget,
                           input string tag);
    int i = 0;
    while (done_cnt == d0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic wait_wr(input int n, input int budget, input string tag);
    int i = 0;
    while (wr_n < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_wr_reached"}, 32'(wr_n >= n), 32'd1);
  endtask

  task automatic chk_cfg(input int b, input logic [31:0] w,
                         input logic [31:0] h, input logic [31:0] a,
                         input logic [31:0] l, input logic [31:0] stride,
                         input logic [31:0] size, input logic [31:0] ctl);
    logic [29:0] ea [0:11];
    logic [31:0] ed [0:11];
    ea = '{FMT + 30'h10, FMT + 30'h11, FMT + 30'h12, FMT + 30'h13,
           FMT + 30'h04, WDMA + 30'h08, WDMA + 30'h09, WDMA + 30'h0A,
           WDMA + 30'h0B, WDMA + 30'h0C, WDMA + 30'h0F, WDMA + 30'h04};
    ed = '{w, h, 32'd0, 32'd1024, 32'd1, a, stride, w, h, size, l, ctl};
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("cfg%0d_adr", i), 32'(wr_adr[b + i]), 32'(ea[i]));
      chk($sformatf("cfg%0d_dat", i), wr_dat[b + i], ed[i]);
    end
  endtask

  initial begin
    int b, r0, d0, s0, i0, k;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_stb", 32'(bus.m_wb_stb_o), 0);
    chk("rst_we", 32'(bus.m_wb_we_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // continuous capture
    b = wr_n; r0 = rd_n; d0 = done_cnt;
    pulse_start(16'd2048, 16'd16, 32'h3000_0000, 8'd31, 1'b0, 1'b0);
    wait_wr(b + 12, 300, "t1");
    repeat (3 * PI + 10) @(negedge clk);
    chk("t1_nwr", 32'(wr_n - b), 12);
    chk_cfg(b, 2048, 16, 32'h3000_0000, 31, 8192, 32768, 3);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_nodone", 32'(done_cnt - d0), 0);
    chk("t1_nopoll", 32'(rd_n - r0), 0);
    pulse_start(16'd1, 16'd1, 32'h0, 8'd0, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    chk("t1_start_ignored", 32'(wr_n - b), 12);

    // stop path with status 1,1,0
    b = wr_n; r0 = rd_n; d0 = done_cnt;
    st_seq[0] = 1; st_seq[1] = 1; st_seq[2] = 0;
    st_len = 3; st_base = rd_n;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done(d0, 300, "t2");
    chk("t2_busy_at_done", 32'(busy), 0);
    chk("t2_nwr", 32'(wr_n - b), 1);
    chk("t2_stop_adr", 32'(wr_adr[b]), 32'(WDMA + 30'h04));
    chk("t2_stop_dat", wr_dat[b], 0);
    chk("t2_nrd", 32'(rd_n - r0), 3);
    repeat (5) @(negedge clk);
    chk("t2_ndone", 32'(done_cnt - d0), 1);

    // oneshot, polled status 1,1,0
    b = wr_n; r0 = rd_n; d0 = done_cnt;
    st_base = rd_n;
    pulse_start(16'd320, 16'd64, 32'h1000_0000, 8'd15, 1'b1, 1'b0);
    wait_done(d0, 400, "t3");
    repeat (5) @(negedge clk);
    chk("t3_nwr", 32'(wr_n - b), 12);
    chk_cfg(b, 320, 64, 32'h1000_0000, 15, 1280, 20480, 7);
    chk("t3_nrd", 32'(rd_n - r0), 3);
    chk("t3_ndone", 32'(done_cnt - d0), 1);
    chk("t3_busy", 32'(busy), 0);

    // ack timeout on the 5th write
    b = wr_n; d0 = done_cnt;
    noack_at = wr_n + 4;
    pulse_start(16'd8, 16'd8, 32'h0, 8'd0, 1'b0, 1'b0);
    k = 0;
    while (!error && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("t4_error", 32'(error), 1);
    chk("t4_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("t4_stb_len", 32'(last_run), TO);
    chk("t4_nwr", 32'(wr_n - b), 4);
    s0 = stb_total;
    repeat (20) @(negedge clk);
    chk("t4_quiet", 32'(stb_total - s0), 0);
    chk("t4_nodone", 32'(done_cnt - d0), 0);
    noack_at = -1;
    pulse_start(16'd8, 16'd8, 32'h0, 8'd0, 1'b0, 1'b0);
    chk("t4_err_clr", 32'(error), 0);
    chk("t4_busy2", 32'(busy), 1);

    // async reset mid-write
    k = 0;
    while (!bus.m_wb_stb_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t5_stb_seen", 32'(bus.m_wb_stb_o), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_stb_async", 32'(bus.m_wb_stb_o), 0);
    chk("t5_busy", 32'(busy), 0);
    b = wr_n; s0 = stb_total;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("t5_nwr", 32'(wr_n - b), 0);
    chk("t5_quiet", 32'(stb_total - s0), 0);
    chk("t5_idle", 32'(busy), 0);

    // start and stop together: stop latched, status 0
    b = wr_n; r0 = rd_n; d0 = done_cnt;
    st_seq[0] = 0; st_len = 1; st_base = rd_n;
    pulse_start(16'd64, 16'd2, 32'h100, 8'd3, 1'b0, 1'b1);
    wait_done(d0, 300, "t7");
    chk("t7_nwr", 32'(wr_n - b), 13);
    chk("t7_size", wr_dat[b + 9], 128);
    chk("t7_stop_adr", 32'(wr_adr[b + 12]), 32'(WDMA + 30'h04));
    chk("t7_stop_dat", wr_dat[b + 12], 0);
    chk("t7_nrd", 32'(rd_n - r0), 1);

`ifdef WB_CAPTURE_SEQ_ID_CHECK_EN
    // bad WDMA id
    b = wr_n; i0 = id_n;
    wdma_id = 32'h0;
    pulse_start(16'd8, 16'd8, 32'h0, 8'd0, 1'b0, 1'b0);
    k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t6_error", 32'(error), 1);
    chk("t6_nwr", 32'(wr_n - b), 0);
    chk("t6_nid", 32'(id_n - i0), 2);
    wdma_id = 32'h0000_5678;
`else
    i0 = id_n;
    chk("t6_no_id_reads", 32'(i0), 0);
`endif

    chk("busy_falls_with_done", 32'(busy_bad), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
